// File: rtl/prog_seq_pkg.sv
// Shared state encoding, default widths and result record for the program sequencer.
package prog_seq_pkg;

    localparam int unsigned DefCntW = 16;
    localparam int unsigned DefPgmW = 2;

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        LAUNCH,
        ARM,
        RUN,
        DONE,
        FAULT
    } seq_state_t;

    typedef struct packed {
        logic [DefPgmW-1:0] pgm;
        logic [DefCntW-1:0] cycles;
    } seq_res_t;

endpackage

// File: rtl/seq_cycle_ctr.sv
// Saturating counter with clear/enable; stops at Limit and flags it.
module seq_cycle_ctr #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clr,
    input  logic             En,
    input  logic [CNT_W-1:0] Limit,
    output logic [CNT_W-1:0] Count,
    output logic             AtMax
);

    assign AtMax = (Count == Limit);

    // Clr together with En loads 1 so the first counted cycle already reads 1.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Count <= '0;
        end else if (Clr) begin
            Count <= CNT_W'(En);
        end else if (En && !AtMax) begin
            Count <= Count + 1'b1;
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Runs a batch of programs on the core and times each one from Start fall to Ack rise.
// Optional watchdog with FAULT state when PROG_SEQ_WDOG_EN is defined.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int unsigned START_CYC = 2,
    parameter int unsigned CNT_W     = DefCntW,
    parameter int unsigned PGM_W     = DefPgmW
`ifdef PROG_SEQ_WDOG_EN
   ,parameter int unsigned WDOG_MAX  = 16'hFFFF
`endif
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic [PGM_W-1:0] NumPgms,
    input  logic             Ack,
    output logic             CoreReset,
    output logic             Start,
    output logic             Busy,
    output logic             ResValid,
    output logic [PGM_W-1:0] ResPgm,
    output logic [CNT_W-1:0] ResCycles,
    output logic             AllDone,
    output logic             Fault
);

    localparam logic [CNT_W-1:0] StartLimit = CNT_W'(START_CYC - 1);
`ifdef PROG_SEQ_WDOG_EN
    localparam logic [CNT_W-1:0] RunLimit = CNT_W'(WDOG_MAX);
`else
    localparam logic [CNT_W-1:0] RunLimit = '1;
`endif

    seq_state_t       stateQ, stateD;
    logic [PGM_W-1:0] idxQ, idxD, lastQ, lastD;
    logic [CNT_W-1:0] cnt, limit;
    logic             cntClr, cntEn, cntAtMax, wdogHit, done;

    // One counter serves both the Start hold and the run-time measurement.
    assign limit = (stateQ == LAUNCH) ? StartLimit : RunLimit;

`ifdef PROG_SEQ_WDOG_EN
    assign wdogHit = cntAtMax;
`else
    assign wdogHit = 1'b0;
`endif

    assign cntClr = (stateD != stateQ) && ((stateD == LAUNCH) || (stateD == ARM));
    assign cntEn  = ((stateQ == LAUNCH) && (stateD == LAUNCH)) || (stateD == ARM) ||
                    (stateD == RUN);

    seq_cycle_ctr #(
        .CNT_W (CNT_W)
    ) u_ctr (
        .Clk   (Clk),
        .Reset (Reset),
        .Clr   (cntClr),
        .En    (cntEn),
        .Limit (limit),
        .Count (cnt),
        .AtMax (cntAtMax)
    );

    always_comb begin
        stateD = stateQ;
        idxD   = idxQ;
        lastD  = lastQ;
        done   = 1'b0;
        case (stateQ)
            IDLE, DONE, FAULT: begin
                if (Go) begin
                    stateD = CRST;
                    idxD   = '0;
                    lastD  = (NumPgms == '0) ? '0 : NumPgms - 1'b1;
                end
            end
            CRST:   stateD = LAUNCH;
            LAUNCH: if (cntAtMax) stateD = ARM;
            // A stale Ack from the previous program must drop before timing starts.
            ARM: begin
                if (wdogHit) begin
                    stateD = FAULT;
                end else if (!Ack) begin
                    stateD = RUN;
                end
            end
            RUN: begin
                if (Ack) begin
                    done = 1'b1;
                    if (idxQ == lastQ) begin
                        stateD = DONE;
                    end else begin
                        idxD   = idxQ + 1'b1;
                        stateD = LAUNCH;
                    end
                end else if (wdogHit) begin
                    stateD = FAULT;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stateQ    <= IDLE;
            idxQ      <= '0;
            lastQ     <= '0;
            CoreReset <= 1'b1;
            Start     <= 1'b0;
            Busy      <= 1'b0;
            ResValid  <= 1'b0;
            ResPgm    <= '0;
            ResCycles <= '0;
            AllDone   <= 1'b0;
        end else begin
            stateQ    <= stateD;
            idxQ      <= idxD;
            lastQ     <= lastD;
            CoreReset <= (stateD == IDLE) || (stateD == CRST) || (stateD == FAULT);
            Start     <= (stateD == LAUNCH);
            Busy      <= (stateD == CRST) || (stateD == LAUNCH) || (stateD == ARM) ||
                         (stateD == RUN);
            ResValid  <= done;
            AllDone   <= (stateD == DONE);
            if (done) begin
                ResPgm    <= idxQ;
                ResCycles <= cnt;
            end
        end
    end

`ifdef PROG_SEQ_WDOG_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Fault <= 1'b0;
        end else begin
            Fault <= (stateD == FAULT);
        end
    end
`else
    assign Fault = 1'b0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: timeline model of the sequencer plus a reactive core Ack model.
module tb_prog_sequencer;

    localparam int S      = 2;
    localparam int CW     = 8;
    localparam int PW     = 2;
    localparam int Wdog   = 50;
    localparam int MaxCnt = (1 << CW) - 1;
`ifdef PROG_SEQ_WDOG_EN
    localparam bit WdogOn = 1'b1;
`else
    localparam bit WdogOn = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Go = 1'b0;
    logic [PW-1:0] NumPgms = '0;
    logic          Ack = 1'b0;
    logic          CoreReset, Start, Busy, ResValid, AllDone, Fault;
    logic [PW-1:0] ResPgm;
    logic [CW-1:0] ResCycles;

    prog_sequencer #(
        .START_CYC (S),
        .CNT_W     (CW),
        .PGM_W     (PW)
`ifdef PROG_SEQ_WDOG_EN
       ,.WDOG_MAX  (Wdog)
`endif
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Go        (Go),
        .NumPgms   (NumPgms),
        .Ack       (Ack),
        .CoreReset (CoreReset),
        .Start     (Start),
        .Busy      (Busy),
        .ResValid  (ResValid),
        .ResPgm    (ResPgm),
        .ResCycles (ResCycles),
        .AllDone   (AllDone),
        .Fault     (Fault)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    bit cmpEn = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Core model: per program, Ack high for cycles 1..pre after Start falls and from cycle d on.
    int specPre[16];
    int specD[16];
    int specN = 0;
    int specRd = 0;
    int drvK = 0, drvPre = 0, drvD = 0;
    bit drvIn = 1'b0;
    logic prevStart = 1'b0;

    task automatic addSpec(input int pre, input int d);
        specPre[specN] = pre;
        specD[specN]   = d;
        specN++;
    endtask

    always @(posedge Clk) begin
        #1;
        if (!Reset) begin
            Ack   = 1'b0;
            drvIn = 1'b0;
        end else if (Start && !prevStart) begin
            if (specRd < specN) begin
                drvPre = specPre[specRd];
                drvD   = specD[specRd];
                specRd++;
            end else begin
                drvPre = 0;
                drvD   = 0;
            end
            drvIn = 1'b0;
            Ack   = (drvPre > 0);
        end else if (!Start && prevStart) begin
            drvIn = 1'b1;
            drvK  = 1;
            Ack   = (drvK <= drvPre) || (drvD > 0 && drvK >= drvD);
        end else if (drvIn) begin
            drvK++;
            Ack = (drvK <= drvPre) || (drvD > 0 && drvK >= drvD);
        end
        prevStart = Start;
    end

    // Timeline model: edge numbers of launches; cycle k counts from the Start-fall edge.
    int mE = 0, mLaunchAt = 0, mPg = 0, mLast = 0, mK = 0;
    bit mActive = 0, mSeenLow = 0, mAllDone = 0, mFault = 0;
    bit mResValid = 0;
    int mResPgm = 0, mResCycles = 0;
    bit eStart = 0, eBusy = 0, eCoreReset = 1;

    always @(posedge Clk) begin
        mE++;
        mResValid = 1'b0;
        if (!Reset) begin
            mActive  = 1'b0;
            mAllDone = 1'b0;
            mFault   = 1'b0;
        end else if (!mActive) begin
            if (Go) begin
                mActive   = 1'b1;
                mPg       = 0;
                mLast     = (NumPgms == 0) ? 0 : int'(NumPgms) - 1;
                mLaunchAt = mE + 1;
                mSeenLow  = 1'b0;
                mAllDone  = 1'b0;
                mFault    = 1'b0;
            end
        end else begin
            mK = mE - (mLaunchAt + S);
            if (mK >= 1) begin
                if (mSeenLow && Ack) begin
                    mResValid  = 1'b1;
                    mResPgm    = mPg;
                    mResCycles = (mK > MaxCnt) ? MaxCnt : mK;
                    if (mPg == mLast) begin
                        mActive  = 1'b0;
                        mAllDone = 1'b1;
                    end else begin
                        mPg++;
                        mLaunchAt = mE;
                        mSeenLow  = 1'b0;
                    end
                end else if (WdogOn && mK == Wdog) begin
                    mActive = 1'b0;
                    mFault  = 1'b1;
                end else if (!Ack) begin
                    mSeenLow = 1'b1;
                end
            end
        end
        eStart     = mActive && mE >= mLaunchAt && mE < mLaunchAt + S;
        eBusy      = mActive;
        eCoreReset = (!mActive && !mAllDone) || (mActive && mPg == 0 && mE < mLaunchAt);
    end

    int gotPgm[$];
    int gotCyc[$];

    always @(negedge Clk) begin
        if (cmpEn) begin
            if (!Reset) begin
                chk("rst_corereset", CoreReset, 1);
                chk("rst_start", Start, 0);
                chk("rst_busy", Busy, 0);
                chk("rst_resvalid", ResValid, 0);
                chk("rst_respgm", ResPgm, 0);
                chk("rst_rescycles", ResCycles, 0);
                chk("rst_alldone", AllDone, 0);
                chk("rst_fault", Fault, 0);
            end else begin
                chk("start", Start, eStart);
                chk("busy", Busy, eBusy);
                chk("corereset", CoreReset, eCoreReset);
                chk("alldone", AllDone, mAllDone);
                chk("fault", Fault, mFault);
                chk("resvalid", ResValid, mResValid);
                if (mResValid) begin
                    chk("respgm", ResPgm, mResPgm);
                    chk("rescycles", ResCycles, mResCycles);
                end
                if (ResValid) begin
                    gotPgm.push_back(int'(ResPgm));
                    gotCyc.push_back(int'(ResCycles));
                end
            end
        end
    end

    task automatic goRun(input int n, input string name);
        int lat;
        NumPgms = PW'(n);
        Go = 1'b1;
        tick();
        Go  = 1'b0;
        lat = 1;
        chk({name, "_busy_on_go"}, Busy, 1);
        chk({name, "_alldone_clr"}, AllDone, 0);
        chk({name, "_fault_clr"}, Fault, 0);
        while (!Start && lat < 10) begin
            tick();
            lat++;
        end
        chk({name, "_go_to_start"}, lat, 2);
    endtask

    task automatic waitSig(input bit wantFault, input int budget, input string name);
        int n = 0;
        while (!(wantFault ? Fault : AllDone) && n < budget) begin
            tick();
            n++;
        end
        chk(name, wantFault ? Fault : AllDone, 1);
    endtask

    task automatic chkRes(input int idx, input int pgm, input int cyc, input string name);
        if (idx < gotPgm.size()) begin
            chk({name, "_pgm"}, gotPgm[idx], pgm);
            chk({name, "_cycles"}, gotCyc[idx], cyc);
        end else begin
            chk({name, "_missing"}, gotPgm.size(), idx + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=0", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        int base;
        // 1: asynchronous reset mid-clock
        @(posedge Clk);
        #3;
        Reset = 1'b0;
        #1;
        chk("t1_corereset", CoreReset, 1);
        chk("t1_start", Start, 0);
        chk("t1_busy", Busy, 0);
        chk("t1_resvalid", ResValid, 0);
        chk("t1_alldone", AllDone, 0);
        chk("t1_fault", Fault, 0);
        cmpEn = 1'b1;
        repeat (3) tick();
        Reset = 1'b1;
        repeat (2) tick();

        // 2: three programs, Ack 10/20/30 cycles after Start falls
        base = gotPgm.size();
        addSpec(0, 10);
        addSpec(0, 20);
        addSpec(0, 30);
        goRun(3, "t2");
        waitSig(1'b0, 300, "t2_alldone");
        tick();
        chk("t2_count", gotPgm.size() - base, 3);
        chkRes(base, 0, 10, "t2_r0");
        chkRes(base + 1, 1, 20, "t2_r1");
        chkRes(base + 2, 2, 30, "t2_r2");
        chk("t2_busy", Busy, 0);
        chk("t2_corereset", CoreReset, 0);

        // 3: NumPgms=0 runs exactly one program
        base = gotPgm.size();
        addSpec(0, 7);
        goRun(0, "t3");
        waitSig(1'b0, 100, "t3_alldone");
        repeat (5) tick();
        chk("t3_count", gotPgm.size() - base, 1);
        chkRes(base, 0, 7, "t3_r0");

        // 4: stale Ack high through LAUNCH and five ARM cycles, real Ack at cycle 12
        base = gotPgm.size();
        addSpec(5, 12);
        goRun(1, "t4");
        waitSig(1'b0, 100, "t4_alldone");
        repeat (3) tick();
        chk("t4_count", gotPgm.size() - base, 1);
        chkRes(base, 0, 12, "t4_r0");

        // 5a: Go while Busy is ignored (NumPgms changed to expose a wrong accept)
        base = gotPgm.size();
        addSpec(0, 15);
        addSpec(0, 15);
        goRun(2, "t5");
        repeat (5) tick();
        chk("t5_busy_at_repulse", Busy, 1);
        NumPgms = 2'd3;
        Go = 1'b1;
        tick();
        Go = 1'b0;
        waitSig(1'b0, 200, "t5_alldone");
        repeat (3) tick();
        chk("t5_count", gotPgm.size() - base, 2);
        chkRes(base, 0, 15, "t5_r0");
        chkRes(base + 1, 1, 15, "t5_r1");

        // 5b: reset during RUN returns to idle with no result
        base = gotPgm.size();
        goRun(1, "t5b");
        repeat (12) tick();
        chk("t5b_busy_in_run", Busy, 1);
        @(posedge Clk);
        #3;
        Reset = 1'b0;
        #1;
        chk("t5b_rst_busy", Busy, 0);
        chk("t5b_rst_corereset", CoreReset, 1);
        chk("t5b_rst_start", Start, 0);
        repeat (2) tick();
        Reset = 1'b1;
        repeat (5) tick();
        chk("t5b_no_result", gotPgm.size() - base, 0);

        // 6: watchdog, or saturation when the watchdog is absent
        base = gotPgm.size();
        addSpec(0, 300);
        goRun(1, "t6");
`ifdef PROG_SEQ_WDOG_EN
        waitSig(1'b1, 150, "t6_fault");
        tick();
        chk("t6_corereset", CoreReset, 1);
        chk("t6_alldone", AllDone, 0);
        chk("t6_busy", Busy, 0);
        chk("t6_no_result", gotPgm.size() - base, 0);
        base = gotPgm.size();
        addSpec(0, 5);
        goRun(1, "t6r");
        waitSig(1'b0, 100, "t6r_alldone");
        repeat (3) tick();
        chkRes(base, 0, 5, "t6r_r0");
        chk("t6r_fault", Fault, 0);
`else
        repeat (200) tick();
        chk("t6_fault", Fault, 0);
        chk("t6_busy", Busy, 1);
        waitSig(1'b0, 400, "t6_alldone");
        repeat (3) tick();
        chkRes(base, 0, MaxCnt, "t6_sat");
        chk("t6_fault_end", Fault, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
